sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller_pkg.sv | 34 +++
 rtl/sram_controller.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sram_controller_pkg.sv
// Shared constants for the memory stage: SRAM controller states, default
// address map and the EXE command codes used by the execute stage.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } sram_state_t;

  localparam int unsigned SRAM_ADDR_BASE_DEFAULT = 32'd1024;
  localparam int unsigned SRAM_WAIT_DEFAULT      = 32'd1;

  typedef enum logic [3:0] {
    EXE_MOV = 4'd1,
    EXE_MVN = 4'd9,
    EXE_ADD = 4'd2,
    EXE_ADC = 4'd3,
    EXE_SUB = 4'd4,
    EXE_SBC = 4'd5,
    EXE_AND = 4'd6,
    EXE_ORR = 4'd7,
    EXE_EOR = 4'd8,
    EXE_LDR = 4'd10,
    EXE_STR = 4'd11
  } exe_cmd_t;

  // Word index into the 16-bit SRAM; the subtraction wraps modulo 2^32.
  function automatic logic [16:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    return 17'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Memory-stage controller that splits each 32-bit load/store into two
// 16-bit SRAM phases (low half, then high half) and stalls the pipeline meanwhile.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned ADDR_BASE = SRAM_ADDR_BASE_DEFAULT,
  parameter int unsigned SRAM_WAIT = SRAM_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  inout  wire  [15:0] sram_dq,
  output logic [17:0] sram_addr,
  output logic        sram_we_n
);

  sram_state_t r_state;
  sram_state_t w_next_state;
  logic [2:0]  r_phase;
  logic [2:0]  w_next_phase;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_is_write;
  logic [31:0] r_rdata;
  logic        w_req;
  logic        w_phase_last;
  logic [16:0] w_index;
  logic        w_dq_oe;
  logic [15:0] w_dq_out;

  assign w_req        = wr_en | rd_en;
  assign w_phase_last = (r_phase == 3'(SRAM_WAIT));
  assign w_index      = word_index(r_addr, 32'(ADDR_BASE));

  // State and phase counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_phase <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_phase <= w_next_phase;
    end
  end

  // Next-state and phase-counter logic
  always_comb begin
    w_next_state = r_state;
    w_next_phase = r_phase;
    case (r_state)
      ST_IDLE: begin
        w_next_phase = 3'd0;
        if (w_req) w_next_state = ST_LO;
        else       w_next_state = ST_IDLE;
      end
      ST_LO: begin
        if (w_phase_last) begin
          w_next_state = ST_HI;
          w_next_phase = 3'd0;
        end else begin
          w_next_phase = r_phase + 3'd1;
        end
      end
      ST_HI: begin
        if (w_phase_last) begin
          w_next_state = ST_DONE;
          w_next_phase = 3'd0;
        end else begin
          w_next_phase = r_phase + 3'd1;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
        w_next_phase = 3'd0;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_phase = 3'd0;
      end
    endcase
  end

  // Request capture; inputs are ignored until the controller is back in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_is_write <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_req) begin
      r_addr     <= address;
      r_wdata    <= wdata;
      r_is_write <= wr_en;
    end else begin
      r_addr     <= r_addr;
      r_wdata    <= r_wdata;
      r_is_write <= r_is_write;
    end
  end

  // Read data capture on the last cycle of each phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'd0;
    end else if (!r_is_write && w_phase_last && (r_state == ST_LO)) begin
      r_rdata[15:0] <= sram_dq;
    end else if (!r_is_write && w_phase_last && (r_state == ST_HI)) begin
      r_rdata[31:16] <= sram_dq;
    end else begin
      r_rdata <= r_rdata;
    end
  end

  // SRAM pin decode from the registered state and captured request
  always_comb begin
    sram_addr = 18'd0;
    sram_we_n = 1'b1;
    w_dq_oe   = 1'b0;
    w_dq_out  = 16'd0;
    case (r_state)
      ST_LO: begin
        sram_addr = {w_index, 1'b0};
        sram_we_n = ~r_is_write;
        w_dq_oe   = r_is_write;
        w_dq_out  = r_wdata[15:0];
      end
      ST_HI: begin
        sram_addr = {w_index, 1'b1};
        sram_we_n = ~r_is_write;
        w_dq_oe   = r_is_write;
        w_dq_out  = r_wdata[31:16];
      end
      default: begin
        sram_addr = 18'd0;
        sram_we_n = 1'b1;
        w_dq_oe   = 1'b0;
        w_dq_out  = 16'd0;
      end
    endcase
  end

  // Stall decode: a new request in IDLE stalls at once, DONE releases the pipeline
  always_comb begin
    ready = 1'b0;
    case (r_state)
      ST_IDLE: ready = ~w_req;
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign sram_dq = w_dq_oe ? w_dq_out : 16'bz;
  assign rdata   = r_rdata;

endmodule
